// File: rtl/ofm_mem_arbiter_if.sv
// ofm_mem_arbiter_if: producer/consumer/memory bus around the OFM memory arbiter.
interface ofm_mem_arbiter_if #(
    parameter int WIDTH = 172
);
    localparam int AW = $clog2(WIDTH);
    logic              wr_req;
    logic [AW-1:0]     wr_addr;
    logic [0:3][7:0]   wr_data;
    logic              wr_gnt;
    logic              rd_req;
    logic [AW-1:0]     rd_addr;
    logic              rd_gnt;
    logic [0:3][7:0]   rd_data;
    logic              rd_valid;
    logic [AW-1:0]     mem_addr;
    logic              mem_write_en;
    logic [0:3][7:0]   mem_inp;
    logic [0:3][7:0]   mem_data_out;
    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_data_out,
        output wr_gnt, rd_gnt, rd_data, rd_valid, mem_addr, mem_write_en, mem_inp
    );
    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_data_out,
        input  wr_gnt, rd_gnt, rd_data, rd_valid, mem_addr, mem_write_en, mem_inp
    );
endinterface

// File: rtl/ofm_mem_arbiter.sv
// ofm_mem_arbiter: round-robin write/read arbiter in front of the OFM memory, with layer-complete tracking.
module ofm_mem_arbiter #(
    parameter int WIDTH     = 172,
    parameter int NUM_WORDS = 43,
    localparam int CW       = $clog2(NUM_WORDS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    ofm_mem_arbiter_if.slave    bus,
    output logic                done,
    output logic [CW-1:0]       wr_cnt,
    output logic                align_err
);
    typedef enum logic {RUN, DONE} state_t;
    state_t state, state_nxt;
    logic prio, aligned, wr_ok, rd_ok, last;
    // Grants are masked by reset and clear so nothing reaches the memory in those cycles.
    always_comb begin
        aligned          = bus.wr_addr[1:0] == 2'b00;
        wr_ok            = rst_n & ~clear & bus.wr_req & (state == RUN);
        rd_ok            = rst_n & ~clear & bus.rd_req;
        bus.wr_gnt       = wr_ok & (~rd_ok | ~prio);
        bus.rd_gnt       = rd_ok & (~wr_ok | prio);
        bus.mem_addr     = bus.wr_gnt ? bus.wr_addr : bus.rd_gnt ? bus.rd_addr : '0;
        bus.mem_write_en = bus.wr_gnt & aligned;
        bus.mem_inp      = bus.wr_data;
        last             = bus.mem_write_en && (wr_cnt == CW'(NUM_WORDS - 1));
        state_nxt        = clear ? RUN : last ? DONE : state;
        done             = state == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio         <= 1'b0;
            wr_cnt       <= '0;
            align_err    <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else if (clear) begin
            prio         <= 1'b0;
            wr_cnt       <= '0;
            align_err    <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            prio         <= bus.wr_gnt ? 1'b1 : bus.rd_gnt ? 1'b0 : prio;
            wr_cnt       <= wr_cnt + CW'(bus.mem_write_en);
            align_err    <= align_err | (bus.wr_gnt & ~aligned);
            bus.rd_valid <= bus.rd_gnt;
            if (bus.rd_gnt) bus.rd_data <= bus.mem_data_out;
        end
    end
endmodule

// File: tb/tb_ofm_mem_arbiter.sv
// tb_ofm_mem_arbiter: directed bench with a byte-memory model and a read-data scoreboard.
module tb_ofm_mem_arbiter;
    localparam int WIDTH = 172;
    localparam int NW    = 43;
    localparam int CW    = $clog2(NW + 1);
    logic clk = 1'b0;
    logic rst_n, clear, done, align_err;
    logic [CW-1:0] wr_cnt;
    int total = 0;
    int bad = 0;
    logic [7:0] mem [256] = '{default: 8'h00};
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    logic [0:3][7:0] sb_q [$];
    logic [0:3][7:0] e_rd;

    ofm_mem_arbiter_if #(.WIDTH(WIDTH)) bus ();
    ofm_mem_arbiter #(.WIDTH(WIDTH), .NUM_WORDS(NW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
        .done(done), .wr_cnt(wr_cnt), .align_err(align_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.mem_write_en)
            for (int i = 0; i < 4; i++) mem[int'(bus.mem_addr) + i] <= bus.mem_inp[i];

    always_comb
        for (int i = 0; i < 4; i++) bus.mem_data_out[i] = mem[int'(bus.mem_addr) + i];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: reads push the expected word, rd_valid pops and compares it.
    always @(negedge clk) begin
        if (bus.rd_valid) begin
            chk("sb_pending", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) chk("rd_data_sb", bus.rd_data, sb_q.pop_front());
        end
        if (!rst_n) sb_q.delete();
        if (bus.rd_gnt) begin
            for (int i = 0; i < 4; i++) e_rd[i] = ref_mem[int'(bus.rd_addr) + i];
            sb_q.push_back(e_rd);
        end
        if (bus.wr_gnt && bus.wr_addr[1:0] == 2'b00)
            for (int i = 0; i < 4; i++) ref_mem[int'(bus.wr_addr) + i] <= bus.wr_data[i];
    end

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        bus.wr_addr = '0;
        bus.rd_addr = '0;
        bus.wr_data = 32'hA0A1A2A3;
        #12;
        chk("rst_wr_gnt", bus.wr_gnt, 0);
        chk("rst_rd_gnt", bus.rd_gnt, 0);
        chk("rst_mem_we", bus.mem_write_en, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_cnt", wr_cnt, 0);
        chk("rst_align", align_err, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        step();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_wr_gnt", bus.wr_gnt, 64'(i % 2 == 0));
            chk("rr_rd_gnt", bus.rd_gnt, 64'(i % 2 == 1));
            step();
        end
        chk("rr_wr_cnt", wr_cnt, 2);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        #1;
        chk("idle_mem_addr", bus.mem_addr, 0);
        chk("idle_wr_gnt", bus.wr_gnt, 0);
        chk("idle_rd_gnt", bus.rd_gnt, 0);
        bus.wr_req = 1'b1;
        bus.wr_addr = 8'd8;
        bus.wr_data = 32'h11223344;
        #1;
        chk("wr8_gnt", bus.wr_gnt, 1);
        chk("wr8_we", bus.mem_write_en, 1);
        chk("wr8_addr", bus.mem_addr, 8);
        step();
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b1;
        bus.rd_addr = 8'd8;
        #1;
        chk("rd8_gnt", bus.rd_gnt, 1);
        chk("rd8_addr", bus.mem_addr, 8);
        chk("rd8_valid_early", bus.rd_valid, 0);
        step();
        bus.rd_req = 1'b0;
        #1;
        chk("rd8_valid", bus.rd_valid, 1);
        chk("rd8_data", bus.rd_data, 32'h11223344);
        step();
        chk("rd8_valid_pulse", bus.rd_valid, 0);
        chk("rd8_data_hold", bus.rd_data, 32'h11223344);
        bus.wr_req = 1'b1;
        bus.wr_addr = 8'd5;
        #1;
        chk("mis_gnt", bus.wr_gnt, 1);
        chk("mis_we", bus.mem_write_en, 0);
        step();
        bus.wr_req = 1'b0;
        #1;
        chk("mis_align_err", align_err, 1);
        chk("mis_wr_cnt", wr_cnt, 3);
        bus.wr_req = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.wr_addr = 8'(4 * i);
            bus.wr_data = $urandom;
            #1;
            chk("stream_wr_gnt", bus.wr_gnt, 1);
            step();
        end
        chk("stream_wr_cnt", wr_cnt, 20);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_cnt", wr_cnt, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_align", align_err, 0);
        chk("mid_rst_rd_valid", bus.rd_valid, 0);
        chk("mid_rst_rd_data", bus.rd_data, 0);
        chk("mid_rst_wr_gnt", bus.wr_gnt, 0);
        chk("mid_rst_we", bus.mem_write_en, 0);
        step();
        rst_n = 1'b1;
        bus.wr_addr = '0;
        #1;
        chk("post_rst_wr_gnt", bus.wr_gnt, 1);
        step();
        chk("post_rst_wr_cnt", wr_cnt, 1);
        for (int i = 1; i <= 42; i++) begin
            bus.wr_addr = 8'(4 * i);
            bus.wr_data = $urandom;
            #1;
            chk("comp_wr_gnt", bus.wr_gnt, 1);
            if (i == 42) chk("comp_done_early", done, 0);
            step();
        end
        chk("comp_done", done, 1);
        chk("comp_wr_cnt", wr_cnt, 43);
        bus.rd_req = 1'b1;
        bus.rd_addr = 8'd8;
        #1;
        chk("done_wr_gnt", bus.wr_gnt, 0);
        chk("done_rd_gnt", bus.rd_gnt, 1);
        step();
        bus.rd_req = 1'b0;
        #1;
        chk("done_rd_valid", bus.rd_valid, 1);
        chk("done_wr_gnt2", bus.wr_gnt, 0);
        step();
        chk("done_wr_cnt", wr_cnt, 43);
        chk("done_sticky", done, 1);
        bus.rd_req = 1'b1;
        clear = 1'b1;
        #1;
        chk("clr_wr_gnt", bus.wr_gnt, 0);
        chk("clr_rd_gnt", bus.rd_gnt, 0);
        step();
        clear = 1'b0;
        #1;
        chk("clr_done", done, 0);
        chk("clr_wr_cnt", wr_cnt, 0);
        chk("clr_rd_valid", bus.rd_valid, 0);
        chk("clr_rd_data", bus.rd_data, 0);
        chk("clr_next_wr_gnt", bus.wr_gnt, 1);
        chk("clr_next_rd_gnt", bus.rd_gnt, 0);
        step();
        chk("clr_wr_cnt1", wr_cnt, 1);
        chk("clr_rr_rd_gnt", bus.rd_gnt, 1);
        step();
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        repeat (3) step();
        chk("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ofm_mem_arbiter.md
OFM_MEM_ARBITER -- requirements
Module: ofm_mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 172: byte depth of the attached ofm_memory; AW = $clog2(WIDTH).
REQ-002 Parameter NUM_WORDS, default 43: accepted writes after which the layer is complete.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 clear  in  1  synchronous restart of the layer; ignored while rst_n is low.
REQ-006 wr_req  in  1  producer write request, held until granted.
REQ-007 wr_addr  in  AW  producer byte address; must be 4-aligned.
REQ-008 wr_data  in  8 x [0:3]  producer bytes; byte 0 goes to the lowest address.
REQ-009 wr_gnt  out  1  write accepted at this clock edge.
REQ-010 rd_req  in  1  consumer read request, held until granted.
REQ-011 rd_addr  in  AW  consumer byte address.
REQ-012 rd_gnt  out  1  read accepted at this clock edge.
REQ-013 rd_data  out  8 x [0:3]  registered read bytes.
REQ-014 rd_valid  out  1  rd_data valid, one-cycle pulse.
REQ-015 mem_addr  out  AW  address to memory.
REQ-016 mem_write_en  out  1  memory write strobe.
REQ-017 mem_inp  out  8 x [0:3]  memory write bytes.
REQ-018 mem_data_out  in  8 x [0:3]  combinational memory read bytes.
REQ-019 done  out  1  sticky layer-complete flag; drives the memory dump.
REQ-020 wr_cnt  out  $clog2(NUM_WORDS+1)  accepted-write count.
REQ-021 align_err  out  1  sticky misaligned-write flag.

Function
REQ-022 States: RUN and DONE; the block leaves reset in RUN.
REQ-023 Priority bit prio (0 = write first): registered; reset value 0.
REQ-024 Grant logic: combinational from the requests, prio and state; at most one of wr_gnt and rd_gnt is high in any cycle.
REQ-025 Grant selection: a single requester is granted; when both request, the prio side is granted; in DONE, wr_gnt stays 0.
REQ-026 Priority update: after any grant, prio points to the non-granted side (round-robin); with no grant, prio is held.
REQ-027 Memory drive: mem_addr = wr_addr when wr_gnt, else rd_addr when rd_gnt, else 0.
REQ-028 Write data: mem_inp = wr_data in all cycles.
REQ-029 Write strobe: mem_write_en = wr_gnt AND wr_addr[1:0]==0.
REQ-030 Misaligned write: granted (consumed) but not written; align_err sets on the next edge.
REQ-031 Read: on a rd_gnt edge, rd_data <= mem_data_out and rd_valid = 1 for exactly the following cycle (latency 1); otherwise rd_valid = 0 and rd_data holds.
REQ-032 Write count: wr_cnt increments on every aligned wr_gnt edge.
REQ-033 Completion: when the increment reaches NUM_WORDS, the state goes to DONE and done = 1 from the next cycle.
REQ-034 Read-after-write: a read granted the cycle after a write to the same address returns the new data.
REQ-035 DONE state: reads continue; writes are never granted; done stays high until clear or reset.
REQ-036 clear: returns to RUN, zeroes wr_cnt, done, align_err, prio, rd_valid and rd_data; no grant in the clear cycle.
REQ-037 clear precedence: clear overrides simultaneous requests.

Reset
REQ-038 rst_n low immediately (asynchronously) sets: state RUN, prio 0, wr_cnt 0, done 0, align_err 0, rd_valid 0, rd_data all 0.
REQ-039 Outputs during reset: wr_gnt, rd_gnt and mem_write_en are 0 while rst_n is low.
REQ-040 Reset mid-transfer: an interrupted transfer is dropped; requesters re-present after release.

Verification
REQ-041 Write, then read: write 0x11223344 bytes to addr 8, then read addr 8 -> rd_valid one cycle later, rd_data = {11,22,33,44}.
REQ-042 Simultaneous requests for 4 cycles from reset -> grant order W, R, W, R.
REQ-043 Completion: 43 aligned writes -> done high the cycle after the 43rd grant; a 44th wr_req is never granted; reads still served.
REQ-044 Misaligned write to addr 5 -> wr_gnt 1, mem_write_en 0, align_err 1, wr_cnt unchanged.
REQ-045 rst_n low mid-stream at wr_cnt = 20 -> all outputs at reset values in the same cycle; first write after release gives wr_cnt = 1.
REQ-046 clear in DONE while wr_req is high -> no grant that cycle; done 0 and write granted on the next cycle.
